// File: rtl/step_dir_pkg.sv
// Shared types and constants for the STEP/DIR receiver.
package step_dir_pkg;

   // Pulse qualification states
   typedef enum logic [1:0] {
      LOW      = 2'd0,
      HIGH_CHK = 2'd1,
      HIGH_OK  = 2'd2
   } step_state_e;

   // Bit positions inside the sticky fault vector
   localparam int FLT_SHORT     = 0;
   localparam int FLT_DIR_SETUP = 1;
   localparam int FLT_DISABLED  = 2;
   localparam int FLT_N         = 3;

   localparam int DEF_PULSES_PER_REV = 384;

endpackage

// File: rtl/step_input_sync.sv
// Two-flop synchronizer for asynchronous pins; both stages clear on reset.
module step_input_sync #(
   parameter int W = 1
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   // Two register stages give metastability time to resolve
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d;
         sync_q <= meta_q;
      end
   end

   assign q = sync_q;

endmodule

// File: rtl/step_dir_receiver.sv
// STEP/DIR/ENABLE receiver: qualifies STEP pulses, tracks signed position,
// index within a revolution and (optionally) step period.
// Optional feature: define STEP_PERIOD_MEASURE_EN to build the period counter;
// otherwise PeriodCycles is tied to zero.
module step_dir_receiver
   import step_dir_pkg::*;
#(
   parameter int POS_W          = 16,
   parameter int MIN_HIGH_CYC   = 50,
   parameter int DIR_SETUP_CYC  = 10,
   parameter int PULSES_PER_REV = DEF_PULSES_PER_REV,
   parameter int PER_W          = 24,
   localparam int REV_W         = $clog2(PULSES_PER_REV)
) (
   input  logic             Clock50MHz,
   input  logic             Reset,
   input  logic             StepIn,
   input  logic             DirIn,
   input  logic             EnableN,
   input  logic             ClearPos,
   input  logic             ClearFault,
   output logic [POS_W-1:0] Position,
   output logic [REV_W-1:0] StepInRev,
   output logic             StepStrobe,
   output logic             RevStrobe,
   output logic [PER_W-1:0] PeriodCycles,
   output logic             FaultShort,
   output logic             FaultDirSetup,
   output logic             FaultDisabled
);

   localparam int HC_W = $clog2(MIN_HIGH_CYC + 1);
   localparam int DC_W = $clog2(DIR_SETUP_CYC + 1);
   localparam logic [REV_W-1:0] REV_LAST = REV_W'(PULSES_PER_REV - 1);

   logic step_s, dir_s, en_n_s;

   step_input_sync #(.W(1)) u_sync_step (.clk(Clock50MHz), .rst(Reset), .d(StepIn),  .q(step_s));
   step_input_sync #(.W(1)) u_sync_dir  (.clk(Clock50MHz), .rst(Reset), .d(DirIn),   .q(dir_s));
   step_input_sync #(.W(1)) u_sync_en   (.clk(Clock50MHz), .rst(Reset), .d(EnableN), .q(en_n_s));

   step_state_e      state_q, state_d;
   logic [HC_W-1:0]  hi_cnt_q, hi_cnt_d;
   logic             step_dir_q, step_dir_d;
   logic             dir_prev_q, dir_prev_d;
   logic [DC_W-1:0]  dir_cnt_q, dir_cnt_d;
   logic [POS_W-1:0] pos_q, pos_d;
   logic [REV_W-1:0] rev_q, rev_d;
   logic             step_stb_q, step_stb_d;
   logic             rev_stb_q, rev_stb_d;
   logic [FLT_N-1:0] fault_q, fault_d, fault_set;

   // Pulse qualification, DIR setup tracking, position/index update, faults
   always_comb begin
      state_d    = state_q;
      hi_cnt_d   = hi_cnt_q;
      step_dir_d = step_dir_q;
      pos_d      = pos_q;
      rev_d      = rev_q;
      step_stb_d = 1'b0;
      rev_stb_d  = 1'b0;
      fault_set  = '0;

      // Cycles since last DIR edge, saturating at the setup requirement
      dir_prev_d = dir_s;
      dir_cnt_d  = dir_cnt_q;
      if (dir_s != dir_prev_q)
         dir_cnt_d = '0;
      else if (dir_cnt_q != DC_W'(DIR_SETUP_CYC))
         dir_cnt_d = dir_cnt_q + 1'b1;

      case (state_q)
         LOW: begin
            if (step_s) begin
               state_d    = HIGH_CHK;
               hi_cnt_d   = HC_W'(1);
               step_dir_d = dir_s;
               if (dir_cnt_q < DC_W'(DIR_SETUP_CYC))
                  fault_set[FLT_DIR_SETUP] = 1'b1;
            end
         end
         HIGH_CHK: begin
            if (!step_s) begin
               fault_set[FLT_SHORT] = 1'b1;
               state_d = LOW;
            end else if (hi_cnt_q == HC_W'(MIN_HIGH_CYC - 1)) begin
               // This edge is the MIN_HIGH_CYC-th high sample: accept
               state_d = HIGH_OK;
               if (en_n_s) begin
                  fault_set[FLT_DISABLED] = 1'b1;
               end else if (!ClearPos) begin
                  step_stb_d = 1'b1;
                  if (step_dir_q) begin
                     pos_d = pos_q + POS_W'(1);
                     if (rev_q == REV_LAST) begin
                        rev_d     = '0;
                        rev_stb_d = 1'b1;
                     end else begin
                        rev_d = rev_q + REV_W'(1);
                     end
                  end else begin
                     pos_d = pos_q - POS_W'(1);
                     if (rev_q == '0) begin
                        rev_d     = REV_LAST;
                        rev_stb_d = 1'b1;
                     end else begin
                        rev_d = rev_q - REV_W'(1);
                     end
                  end
               end
            end else begin
               hi_cnt_d = hi_cnt_q + 1'b1;
            end
         end
         HIGH_OK: begin
            if (!step_s)
               state_d = LOW;
         end
         default: state_d = LOW;
      endcase

      // Clear beats a coincident step; the FSM keeps running
      if (ClearPos) begin
         pos_d = '0;
         rev_d = '0;
      end

      // A fault raised this cycle survives a simultaneous clear
      fault_d = (fault_q & ~{FLT_N{ClearFault}}) | fault_set;
   end

   // State and output registers
   always_ff @(posedge Clock50MHz or posedge Reset) begin
      if (Reset) begin
         state_q    <= LOW;
         hi_cnt_q   <= '0;
         step_dir_q <= 1'b0;
         dir_prev_q <= 1'b0;
         dir_cnt_q  <= DC_W'(DIR_SETUP_CYC);
         pos_q      <= '0;
         rev_q      <= '0;
         step_stb_q <= 1'b0;
         rev_stb_q  <= 1'b0;
         fault_q    <= '0;
      end else begin
         state_q    <= state_d;
         hi_cnt_q   <= hi_cnt_d;
         step_dir_q <= step_dir_d;
         dir_prev_q <= dir_prev_d;
         dir_cnt_q  <= dir_cnt_d;
         pos_q      <= pos_d;
         rev_q      <= rev_d;
         step_stb_q <= step_stb_d;
         rev_stb_q  <= rev_stb_d;
         fault_q    <= fault_d;
      end
   end

`ifdef STEP_PERIOD_MEASURE_EN
   logic [PER_W-1:0] per_cnt_q, per_cnt_d;
   logic [PER_W-1:0] per_q, per_d;

   // Free-running saturating counter, sampled and restarted on each step
   always_comb begin
      per_d     = per_q;
      per_cnt_d = (per_cnt_q == '1) ? per_cnt_q : per_cnt_q + 1'b1;
      if (step_stb_d) begin
         per_d     = per_cnt_q;
         per_cnt_d = PER_W'(1);
      end
      if (ClearPos) begin
         per_d     = '0;
         per_cnt_d = '1;
      end
   end

   // Period registers; counter starts saturated so the first step reads all-ones
   always_ff @(posedge Clock50MHz or posedge Reset) begin
      if (Reset) begin
         per_cnt_q <= '1;
         per_q     <= '0;
      end else begin
         per_cnt_q <= per_cnt_d;
         per_q     <= per_d;
      end
   end

   assign PeriodCycles = per_q;
`else
   assign PeriodCycles = '0;
`endif

   assign Position      = pos_q;
   assign StepInRev     = rev_q;
   assign StepStrobe    = step_stb_q;
   assign RevStrobe     = rev_stb_q;
   assign FaultShort    = fault_q[FLT_SHORT];
   assign FaultDirSetup = fault_q[FLT_DIR_SETUP];
   assign FaultDisabled = fault_q[FLT_DISABLED];

endmodule
